// File: rtl/event_rate_counter_pkg.sv
// Shared definitions for the event rate counter and related scaler blocks.
//   state_e  : gate FSM state encoding (IDLE / COUNT)
//   sat_inc  : saturating increment on a value of up to 64 bits, with the
//              all-ones limit passed in so any accumulator width can use it
package event_rate_counter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } state_e;

   typedef struct packed {
      logic        sat;
      logic [63:0] val;
   } sat_inc_t;

   // sat is set when an increment is attempted with val already at max_val;
   // val then stays at max_val.
   function automatic sat_inc_t sat_inc(input logic [63:0] val,
                                        input logic [63:0] max_val,
                                        input logic        inc);
      sat_inc_t r;
      r.val = val;
      r.sat = 1'b0;
      if (inc) begin
         if (val >= max_val) r.sat = 1'b1;
         else                r.val = val + 64'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/event_gate_timer.sv
// Modulo-GATE_PERIOD gate timer with synchronous restart.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en_i        : count while high; held at 0 while low
//   restart_i   : synchronous return to 0 (timer restarts with the next cycle)
//   tc_o        : terminal count, high on the last cycle of a gate while enabled
module event_gate_timer
   import event_rate_counter_pkg::*;
#(
   parameter int unsigned GATE_PERIOD = 1000000,
   parameter int unsigned GATE_BITS   = 24
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic restart_i,
   output logic tc_o
);

   localparam logic [GATE_BITS-1:0] LAST = GATE_BITS'(GATE_PERIOD - 1);

   logic [GATE_BITS-1:0] timer_q, timer_d;

   assign tc_o = en_i && (timer_q == LAST);

   // Wrapping on terminal count keeps consecutive gates contiguous.
   always_comb begin
      timer_d = timer_q + GATE_BITS'(1);
      if (!en_i || restart_i || tc_o) timer_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) timer_q <= '0;
      else        timer_q <= timer_d;
   end

endmodule

// File: rtl/event_rate_counter.sv
// Gated event rate counter: counts event_i strobes over GATE_PERIOD clocks
// and presents each completed gate's result on a held output.
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable_i       : run gates while high
//   clear_i        : synchronous clear of the result and restart of the gate
//   event_i        : event strobe in the clk domain, one count per high cycle
//   count_o        : saturated count of the last completed gate (held)
//   count_valid_o  : one-cycle pulse when count_o takes a new value
//   overflow_o     : last completed gate saturated (updates with count_o)
//   gate_active_o  : high while a gate is running
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | stopped; accumulator and timer held at 0, result held
// ST_COUNT | gate running; accumulate events until terminal count
module event_rate_counter
   import event_rate_counter_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned GATE_PERIOD = 1000000,
   parameter int unsigned GATE_BITS   = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable_i,
   input  logic             clear_i,
   input  logic             event_i,
   output logic [WIDTH-1:0] count_o,
   output logic             count_valid_o,
   output logic             overflow_o,
   output logic             gate_active_o
);

   if (GATE_PERIOD < 2 || 64'(GATE_PERIOD) > (64'd1 << GATE_BITS)) begin : g_bad_gate
      $error("event_rate_counter: GATE_PERIOD must be in 2 .. 2**GATE_BITS");
   end

   localparam logic [63:0] ACC_MAX = 64'({WIDTH{1'b1}});

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             sat_q, sat_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             vld_q, vld_d;
   logic             gate_end;
   logic             timer_restart;
   sat_inc_t         inc_r;
   logic [63:0]      inc_full;
   logic             unused_inc_bits;

   // Disabling mid-gate throws the partial gate away; the timer follows.
   assign timer_restart = clear_i || !enable_i;

   event_gate_timer #(
      .GATE_PERIOD (GATE_PERIOD),
      .GATE_BITS   (GATE_BITS)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (state_q == ST_COUNT),
      .restart_i (timer_restart),
      .tc_o      (gate_end)
   );

   assign inc_full        = inc_r.val;
   assign unused_inc_bits = ^inc_full;

   always_comb begin
      state_d = enable_i ? ST_COUNT : ST_IDLE;
      acc_d   = acc_q;
      sat_d   = sat_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      vld_d   = 1'b0;
      inc_r   = sat_inc(64'(acc_q), ACC_MAX, event_i);

      if (clear_i) begin
         acc_d   = '0;
         sat_d   = 1'b0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (state_q == ST_IDLE) begin
         acc_d = '0;
         sat_d = 1'b0;
      end else if (gate_end) begin
         // Gate end wins over disable; the final cycle's event is included.
         count_d = WIDTH'(inc_full);
         ovf_d   = sat_q || inc_r.sat;
         vld_d   = 1'b1;
         acc_d   = '0;
         sat_d   = 1'b0;
      end else if (!enable_i) begin
         acc_d = '0;
         sat_d = 1'b0;
      end else begin
         acc_d = WIDTH'(inc_full);
         sat_d = sat_q || inc_r.sat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         sat_q   <= 1'b0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         sat_q   <= sat_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         vld_q   <= vld_d;
      end
   end

   assign count_o       = count_q;
   assign count_valid_o = vld_q;
   assign overflow_o    = ovf_q;
   assign gate_active_o = (state_q == ST_COUNT);

endmodule

// File: tb/tb_event_rate_counter.sv
// Bench for event_rate_counter: two instances (WIDTH=8, gates of 10 and 300
// cycles) share one stimulus stream; a gate-level behavioural model is
// compared every cycle and directed scenarios pin literal results.
module tb_event_rate_counter;

   logic clk = 1'b0;
   logic rst_n, en, clr, ev;

   always #5 clk = ~clk;

   logic [7:0] cnt0, cnt1;
   logic       vld0, vld1, ovf0, ovf1, act0, act1;

   event_rate_counter #(.WIDTH(8), .GATE_PERIOD(10), .GATE_BITS(4)) dut0 (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable_i      (en),
      .clear_i       (clr),
      .event_i       (ev),
      .count_o       (cnt0),
      .count_valid_o (vld0),
      .overflow_o    (ovf0),
      .gate_active_o (act0)
   );

   event_rate_counter #(.WIDTH(8), .GATE_PERIOD(300), .GATE_BITS(9)) dut1 (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable_i      (en),
      .clear_i       (clr),
      .event_i       (ev),
      .count_o       (cnt1),
      .count_valid_o (vld1),
      .overflow_o    (ovf1),
      .gate_active_o (act1)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: a running gate is a number of events seen and a position within
   // the gate; the result is min(events, 255) and overflow is events > 255.
   typedef struct {
      int n;
      int pos;
      int cnt;
      int ovf;
      int vld;
      int run;
   } mst_t;

   int   gp [2] = '{10, 300};
   mst_t m  [2];

   function automatic mst_t mstep(input mst_t s, input int g,
                                  input bit e, input bit c, input bit v);
      mst_t r;
      r     = s;
      r.vld = 0;
      if (c) begin
         r.cnt = 0; r.ovf = 0; r.n = 0; r.pos = 0; r.run = int'(e);
      end else if (r.run == 0) begin
         r.run = int'(e); r.n = 0; r.pos = 0;
      end else begin
         r.n   = r.n + int'(v);
         r.pos = r.pos + 1;
         if (r.pos == g) begin
            r.cnt = (r.n > 255) ? 255 : r.n;
            r.ovf = (r.n > 255) ? 1 : 0;
            r.vld = 1;
            r.n = 0; r.pos = 0; r.run = int'(e);
         end else if (!e) begin
            r.run = 0; r.n = 0; r.pos = 0;
         end
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) m[k] <= '{default: 0};
         else        m[k] <= mstep(m[k], gp[k], en, clr, ev);
      end
   end

   always @(negedge clk) begin
      check("dut0_count",  int'(cnt0), m[0].cnt);
      check("dut0_valid",  int'(vld0), m[0].vld);
      check("dut0_ovf",    int'(ovf0), m[0].ovf);
      check("dut0_active", int'(act0), m[0].run);
      check("dut1_count",  int'(cnt1), m[1].cnt);
      check("dut1_valid",  int'(vld1), m[1].vld);
      check("dut1_ovf",    int'(ovf1), m[1].ovf);
      check("dut1_active", int'(act1), m[1].run);
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Edges until count_valid_o of dut k is seen, bounded by maxc.
   task automatic wait_valid(input int k, input int maxc, output int n);
      logic v;
      n = 0;
      do begin
         cyc(1);
         n++;
         v = (k == 0) ? vld0 : vld1;
      end while (!v && n < maxc);
      check($sformatf("dut%0d_valid_seen", k), int'(v), 1);
   endtask

   int n;

   initial begin
      rst_n = 1'b1; en = 1'b0; clr = 1'b0; ev = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("reset_count", int'(cnt0), 0);
      check("reset_valid", int'(vld0), 0);
      check("reset_ovf",   int'(ovf0), 0);
      check("reset_active", int'(act0), 0);

      // Events tied high: 10 per gate, back-to-back gates.
      cyc(2);
      rst_n = 1'b1; en = 1'b1; ev = 1'b1;
      wait_valid(0, 30, n);
      check("first_latency", n, 11);
      check("tied_high_count", int'(cnt0), 10);
      check("model_tied_high", m[0].cnt, 10);
      check("tied_high_ovf", int'(ovf0), 0);
      wait_valid(0, 30, n);
      check("gate_spacing", n, 10);
      check("tied_high_count2", int'(cnt0), 10);

      // Alternating events: 5 per gate.
      for (int i = 0; i < 30; i++) begin
         ev = i[0];
         cyc(1);
      end
      check("toggle_count", int'(cnt0), 5);
      check("model_toggle", m[0].cnt, 5);

      // Single event on the last cycle of the gate.
      ev = 1'b0;
      cyc(9);
      ev = 1'b1;
      cyc(1);
      ev = 1'b0;
      check("last_cycle_valid", int'(vld0), 1);
      check("last_cycle_count", int'(cnt0), 1);

      // Disable at cycle 6 of a gate, then re-enable.
      ev = 1'b1;
      wait_valid(0, 15, n);
      check("pre_disable_count", int'(cnt0), 10);
      cyc(5);
      en = 1'b0;
      cyc(1);
      check("disable_active", int'(act0), 0);
      check("disable_count", int'(cnt0), 10);
      check("disable_valid", int'(vld0), 0);
      cyc(3);
      check("idle_count_held", int'(cnt0), 10);
      en = 1'b1;
      wait_valid(0, 20, n);
      check("reenable_latency", n, 11);
      check("reenable_count", int'(cnt0), 10);

      // Clear on the gate-end cycle.
      cyc(9);
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      check("clear_count", int'(cnt0), 0);
      check("clear_valid", int'(vld0), 0);
      check("clear_ovf",   int'(ovf0), 0);
      wait_valid(0, 15, n);
      check("post_clear_latency", n, 10);
      check("post_clear_count", int'(cnt0), 10);

      // Asynchronous reset between edges, mid-gate.
      cyc(4);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_count",  int'(cnt0), 0);
      check("async_rst_valid",  int'(vld0), 0);
      check("async_rst_ovf",    int'(ovf0), 0);
      check("async_rst_active", int'(act0), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      wait_valid(0, 20, n);
      check("post_rst_latency", n, 11);
      check("post_rst_count", int'(cnt0), 10);

      // Long gate saturates at 255, then an empty gate clears overflow.
      wait_valid(1, 320, n);
      check("sat_count", int'(cnt1), 255);
      check("sat_ovf",   int'(ovf1), 1);
      check("model_sat", m[1].cnt, 255);
      ev = 1'b0;
      wait_valid(1, 310, n);
      check("empty_gate_latency", n, 300);
      check("empty_count", int'(cnt1), 0);
      check("empty_ovf",   int'(ovf1), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      checks++;
      $display("FAIL global_timeout: got running expected finished");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
